// File: rtl/mig_ui_if.sv
// mig_ui_if: 7-series MIG DDR3 user (app_*) command/write-data/read-data bundle.
interface mig_ui_if;
  logic [29:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;

  // Traffic engine side
  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  // Memory (responder) side
  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_ui_responder.sv
// mig_ui_responder: block-RAM backed stand-in for the MIG DDR3 controller user interface.
// Optional build macro MIG_RESP_STALL_EN adds LFSR-driven random stalls on app_rdy/app_wdf_rdy.
module mig_ui_responder #(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned READ_LATENCY = 8,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input  logic    clk,
  input  logic    rst,
  output logic    init_calib_complete,
  output logic    protocol_err,
  mig_ui_if.slave app
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned QD    = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned PL    = READ_LATENCY - 1;
  localparam int unsigned CALW  = $clog2(CALIB_CYCLES + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic [CALW-1:0]      cal_cnt;
  logic                 calib_nxt_c;

  logic [ADDR_BITS-1:0] wcq_idx [QD];
  logic [PW-1:0]        wcq_wp, wcq_rp;
  logic [CW-1:0]        wcq_cnt, wcq_cnt_nxt_c;

  logic [255:0]         wdf_data [QD];
  logic [31:0]          wdf_mask [QD];
  logic [PW-1:0]        wdf_wp, wdf_rp;
  logic [CW-1:0]        wdf_cnt, wdf_cnt_nxt_c;

  logic [255:0]         mem [DEPTH];
  logic [PL-1:0]        pipe_v;
  logic [255:0]         pipe_d [PL];

  logic [ADDR_BITS-1:0] cmd_idx_c;
  logic                 cmd_acc_c, wr_acc_c, rd_acc_c, wdf_acc_c, commit_c, err_c;
  logic                 stall_cmd_c, stall_wdf_c;
  logic [29-ADDR_BITS-3:0] unused_addr_c;

  assign cmd_idx_c     = app.app_addr[ADDR_BITS+2:3];
  assign unused_addr_c = app.app_addr[29:ADDR_BITS+3];
  assign cmd_acc_c     = app.app_en & app.app_rdy;
  assign wr_acc_c      = cmd_acc_c & (app.app_cmd == CMD_WR);
  assign rd_acc_c      = cmd_acc_c & (app.app_cmd == CMD_RD);
  assign wdf_acc_c     = app.app_wdf_wren & app.app_wdf_rdy;
  assign commit_c      = !rst & (wcq_cnt != '0) & (wdf_cnt != '0);
  assign wcq_cnt_nxt_c = wcq_cnt + CW'(wr_acc_c) - CW'(commit_c);
  assign wdf_cnt_nxt_c = wdf_cnt + CW'(wdf_acc_c) - CW'(commit_c);
  assign calib_nxt_c   = init_calib_complete | (cal_cnt == CALW'(CALIB_CYCLES - 1));
  assign err_c         = (cmd_acc_c & (app.app_cmd > CMD_RD))
                       | (cmd_acc_c & (app.app_addr[2:0] != 3'b000))
                       | (app.app_wdf_wren & !app.app_wdf_end)
                       | (app.app_wdf_wren & !app.app_wdf_rdy);

`ifdef MIG_RESP_STALL_EN
  logic [15:0] lfsr, lfsr_nxt_c;

  // Galois LFSR, taps 16,14,13,11; ready stalls follow the state visible next cycle
  assign lfsr_nxt_c  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign stall_cmd_c = lfsr_nxt_c[0];
  assign stall_wdf_c = lfsr_nxt_c[1];

  // LFSR state
  always_ff @(posedge clk) begin
    if (rst) lfsr <= STALL_SEED;
    else     lfsr <= lfsr_nxt_c;
  end
`else
  logic [15:0] unused_seed_c;
  assign unused_seed_c = STALL_SEED;
  assign stall_cmd_c   = 1'b0;
  assign stall_wdf_c   = 1'b0;
`endif

  // Control: calibration, queue pointers, ready flags, read valid pipeline, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cal_cnt               <= '0;
      init_calib_complete   <= 1'b0;
      wcq_wp                <= '0;
      wcq_rp                <= '0;
      wcq_cnt               <= '0;
      wdf_wp                <= '0;
      wdf_rp                <= '0;
      wdf_cnt               <= '0;
      app.app_rdy           <= 1'b0;
      app.app_wdf_rdy       <= 1'b0;
      pipe_v                <= '0;
      app.app_rd_data_valid <= 1'b0;
      app.app_rd_data_end   <= 1'b0;
      app.app_rd_data       <= '0;
      protocol_err          <= 1'b0;
    end else begin
      if (!init_calib_complete) cal_cnt <= cal_cnt + CALW'(1);
      init_calib_complete <= calib_nxt_c;
      if (wr_acc_c)  wcq_wp <= wcq_wp + PW'(1);
      if (wdf_acc_c) wdf_wp <= wdf_wp + PW'(1);
      if (commit_c) begin
        wcq_rp <= wcq_rp + PW'(1);
        wdf_rp <= wdf_rp + PW'(1);
      end
      wcq_cnt <= wcq_cnt_nxt_c;
      wdf_cnt <= wdf_cnt_nxt_c;
      // Commands wait until every accepted write has been paired with data
      app.app_rdy     <= calib_nxt_c & (wcq_cnt_nxt_c == '0) & !stall_cmd_c;
      app.app_wdf_rdy <= calib_nxt_c & (wdf_cnt_nxt_c != CW'(QD)) & !stall_wdf_c;
      for (int i = int'(PL) - 1; i > 0; i--) pipe_v[i] <= pipe_v[i-1];
      pipe_v[0]             <= rd_acc_c;
      app.app_rd_data_valid <= pipe_v[PL-1];
      app.app_rd_data_end   <= pipe_v[PL-1];
      app.app_rd_data       <= pipe_d[PL-1];
      protocol_err          <= protocol_err | err_c;
    end
  end

  // Storage: queue payloads, byte-masked RAM commit, RAM read and read data pipeline
  always_ff @(posedge clk) begin
    if (wr_acc_c) wcq_idx[wcq_wp] <= cmd_idx_c;
    if (wdf_acc_c) begin
      wdf_data[wdf_wp] <= app.app_wdf_data;
      wdf_mask[wdf_wp] <= app.app_wdf_mask;
    end
    if (commit_c) begin
      for (int b = 0; b < 32; b++) begin
        if (!wdf_mask[wdf_rp][b]) mem[wcq_idx[wcq_rp]][8*b +: 8] <= wdf_data[wdf_rp][8*b +: 8];
      end
    end
    pipe_d[0] <= mem[cmd_idx_c];
    for (int i = int'(PL) - 1; i > 0; i--) pipe_d[i] <= pipe_d[i-1];
  end
endmodule

// File: tb/tb_mig_ui_responder.sv
// tb_mig_ui_responder: directed stimulus with a queue/array memory model checked every cycle.
`timescale 1ns/1ps
module tb_mig_ui_responder;
  localparam int LAT = 8;
  localparam int CAL = 64;
  localparam int AB  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_calib_complete, protocol_err;

  mig_ui_if ui();

  mig_ui_responder #(
    .ADDR_BITS(AB), .READ_LATENCY(LAT), .CALIB_CYCLES(CAL), .STALL_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .protocol_err(protocol_err), .app(ui)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    logic [255:0] d;
  } rd_t;

  rd_t          rdq[$];
  int           wcq_m[$];
  logic [255:0] wdq_d[$];
  logic [31:0]  wdq_k[$];
  logic [255:0] mdl [int];
  int           run = 0;
  bit           exp_err = 1'b0;
  bit           armed = 1'b0;
  int           vcount = 0;
  logic [255:0] last_rd_data = '0;
  int           last_rd_cyc = 0;

  bit           m_cmd_acc, m_wdf_acc;
  int           m_idx, m_widx;
  logic [255:0] m_w, m_d;
  logic [31:0]  m_k;
  rd_t          m_r;

  // Compare this cycle's outputs against the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (armed) begin
      chk1("calib", init_calib_complete, run >= CAL);
      if (run < CAL) begin
        chk1("app_rdy_precal", ui.app_rdy, 1'b0);
        chk1("wdf_rdy_precal", ui.app_wdf_rdy, 1'b0);
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        chk1("rd_valid", ui.app_rd_data_valid, 1'b1);
        chk1("rd_end", ui.app_rd_data_end, 1'b1);
        chkd("rd_data", ui.app_rd_data, rdq[0].d);
        void'(rdq.pop_front());
      end else begin
        chk1("rd_valid_idle", ui.app_rd_data_valid, 1'b0);
        chk1("rd_end_idle", ui.app_rd_data_end, 1'b0);
      end
      chk1("protocol_err", protocol_err, exp_err);
    end
    if (ui.app_rd_data_valid === 1'b1) begin
      vcount++;
      last_rd_data = ui.app_rd_data;
      last_rd_cyc  = cyc;
    end

    if (rst) begin
      armed   = 1'b1;
      run     = 0;
      exp_err = 1'b0;
      rdq.delete();
      wcq_m.delete();
      wdq_d.delete();
      wdq_k.delete();
    end else begin
      if (run < CAL) run++;
      m_cmd_acc = (ui.app_en === 1'b1) && (ui.app_rdy === 1'b1);
      m_wdf_acc = (ui.app_wdf_wren === 1'b1) && (ui.app_wdf_rdy === 1'b1);
      m_idx     = int'(ui.app_addr[AB+2:3]);
      if (m_cmd_acc && ui.app_cmd > 3'd1) exp_err = 1'b1;
      if (m_cmd_acc && ui.app_addr[2:0] != 3'd0) exp_err = 1'b1;
      if (ui.app_wdf_wren === 1'b1 && ui.app_wdf_end !== 1'b1) exp_err = 1'b1;
      if (ui.app_wdf_wren === 1'b1 && ui.app_wdf_rdy !== 1'b1) exp_err = 1'b1;
      if (m_cmd_acc && ui.app_cmd == 3'd0) wcq_m.push_back(m_idx);
      if (m_wdf_acc) begin
        wdq_d.push_back(ui.app_wdf_data);
        wdq_k.push_back(ui.app_wdf_mask);
      end
      while (wcq_m.size() > 0 && wdq_d.size() > 0) begin
        m_widx = wcq_m.pop_front();
        m_d    = wdq_d.pop_front();
        m_k    = wdq_k.pop_front();
        m_w    = mdl.exists(m_widx) ? mdl[m_widx] : '0;
        for (int b = 0; b < 32; b++) if (!m_k[b]) m_w[8*b +: 8] = m_d[8*b +: 8];
        mdl[m_widx] = m_w;
      end
      if (m_cmd_acc && ui.app_cmd == 3'd1) begin
        m_r.due = cyc + LAT;
        m_r.d   = mdl.exists(m_idx) ? mdl[m_idx] : '0;
        rdq.push_back(m_r);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] cmd, input logic [29:0] addr, output int ac);
    int n;
    n = 0;
    ui.app_cmd  = cmd;
    ui.app_addr = addr;
    ui.app_en   = 1'b1;
    while (ui.app_rdy !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk1("cmd_accept", ui.app_rdy, 1'b1);
    ac = cyc;
    tick();
    ui.app_en = 1'b0;
  endtask

  task automatic do_wdf(input logic [255:0] data, input logic [31:0] mask);
    int n;
    n = 0;
    while (ui.app_wdf_rdy !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk1("wdf_accept", ui.app_wdf_rdy, 1'b1);
    if (ui.app_wdf_rdy === 1'b1) begin
      ui.app_wdf_data = data;
      ui.app_wdf_mask = mask;
      ui.app_wdf_wren = 1'b1;
      ui.app_wdf_end  = 1'b1;
      tick();
      ui.app_wdf_wren = 1'b0;
      ui.app_wdf_end  = 1'b0;
    end
  endtask

  task automatic wr(input logic [29:0] addr, input logic [255:0] data, input logic [31:0] mask);
    int ac;
    do_cmd(3'b000, addr, ac);
    do_wdf(data, mask);
  endtask

  task automatic read_chk(input string nm, input logic [29:0] addr, input logic [255:0] exp);
    int ac, v0, n;
    v0 = vcount;
    do_cmd(3'b001, addr, ac);
    n = 0;
    while (vcount == v0 && n < 40) begin
      tick();
      n++;
    end
    chki({nm, "_count"}, vcount - v0, 1);
    chki({nm, "_latency"}, last_rd_cyc - ac, LAT);
    chkd({nm, "_data"}, last_rd_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] d_basic, d_ones, d_masked, d_alias, d_tmp;
    int ac, v0, n;
    d_basic  = {4{64'h0123456789ABCDEF}};
    d_ones   = '1;
    d_masked = {{31{8'hFF}}, 8'h00};
    d_alias  = {8{32'hDEADBEEF}};
    ui.app_addr     = '0;
    ui.app_cmd      = '0;
    ui.app_en       = 1'b0;
    ui.app_wdf_data = '0;
    ui.app_wdf_mask = '0;
    ui.app_wdf_wren = 1'b0;
    ui.app_wdf_end  = 1'b0;

    // Calibration edge: low through cycle 63 after release, high from cycle 64
    rst = 1'b1;
    repeat (3) tick();
    chk1("reset_calib", init_calib_complete, 1'b0);
    chk1("reset_rdy", ui.app_rdy, 1'b0);
    chk1("reset_err", protocol_err, 1'b0);
    chkd("reset_rd_data", ui.app_rd_data, '0);
    rst = 1'b0;
    repeat (63) tick();
    chk1("calib_c63", init_calib_complete, 1'b0);
    chk1("rdy_c63", ui.app_rdy, 1'b0);
    tick();
    chk1("calib_c64", init_calib_complete, 1'b1);
    chk1("rdy_c64", ui.app_rdy, 1'b1);

    // Basic write then read
    wr(30'h40, d_basic, 32'h0);
    read_chk("basic", 30'h40, d_basic);

    // Byte-masked overwrite leaves bytes 1..31 untouched
    wr(30'h80, d_ones, 32'h0);
    wr(30'h80, '0, 32'hFFFF_FFFE);
    read_chk("masked", 30'h80, d_masked);

    // Data ahead of commands fills the 4-deep write data FIFO
    for (int i = 0; i < 4; i++) begin
      d_tmp = {8{32'h1111_0000 + 32'(i)}};
      do_wdf(d_tmp, 32'h0);
    end
    chk1("wdf_rdy_full", ui.app_wdf_rdy, 1'b0);
    for (int i = 0; i < 4; i++) do_cmd(3'b000, 30'h100 + 30'(8 * i), ac);
    v0 = vcount;
    for (int i = 0; i < 4; i++) do_cmd(3'b001, 30'h100 + 30'(8 * i), ac);
    n = 0;
    while (vcount < v0 + 4 && n < 40) begin
      tick();
      n++;
    end
    chki("dbc_count", vcount - v0, 4);
    chkd("dbc_last", last_rd_data, {8{32'h1111_0003}});

    // Upper address bits alias; misaligned column sets the sticky error
    wr(30'h2008, d_alias, 32'h0);
    read_chk("alias", 30'h8, d_alias);
    chk1("err_clean", protocol_err, 1'b0);
    read_chk("misalign", 30'hC, d_alias);
    chk1("err_set", protocol_err, 1'b1);

    // Reset while four reads are in flight: nothing returns, RAM survives
    v0 = vcount;
    for (int i = 0; i < 4; i++) do_cmd(3'b001, 30'h40, ac);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (init_calib_complete !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk1("recal_done", init_calib_complete, 1'b1);
    chki("rst_no_valid", vcount - v0, 0);
    chk1("err_after_rst", protocol_err, 1'b0);
    read_chk("post_rst_basic", 30'h40, d_basic);
    read_chk("post_rst_masked", 30'h80, d_masked);
    read_chk("post_rst_alias", 30'h8, d_alias);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
- Synthesizable responder for the 7-series MIG DDR3 user (app_*) interface: presents app_rdy/app_wdf_rdy, accepts write/read commands, returns read data, backed by on-chip block RAM.
- Drop-in replacement for the DDR3 controller under the ddr3_test traffic engine and the PipeIn/PipeOut FIFOs, for loopback bring-up and simulation without external DDR3.
- Word size 256 bits: one BL8 burst of a 32-bit DDR3 bus in 4:1 mode.

Parameters:
- ADDR_BITS, 10, log2 of depth in 256-bit words (1024 words = 32 KiB).
- READ_LATENCY, 8, cycles from accepted read command to app_rd_data_valid; legal range 2..32.
- CALIB_CYCLES, 64, cycles after rst deasserts before init_calib_complete rises.
- STALL_SEED, 16'hACE1, LFSR seed, used only with MIG_RESP_STALL_EN.

Ports:
- clk  in  1  UI clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- init_calib_complete  out  1  emulated calibration done.
- app_addr  in  30  MIG address in 32-bit column units.
- app_cmd  in  3  000 = write, 001 = read.
- app_en  in  1  command strobe.
- app_rdy  out  1  command accepted when app_en & app_rdy.
- app_wdf_data  in  256  write data.
- app_wdf_mask  in  32  byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data strobe.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren.
- app_wdf_rdy  out  1  data accepted when app_wdf_wren & app_wdf_rdy.
- app_rd_data  out  256  read data.
- app_rd_data_valid  out  1  read data beat valid.
- app_rd_data_end  out  1  equals app_rd_data_valid (one beat per burst).
- protocol_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset:
  - init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end and protocol_err are 0; app_rd_data is 0.
  - The calibration counter, both queues and the read pipeline are cleared.
  - RAM contents are not cleared.
- Calibration:
  - The counter runs from rst deassertion.
  - init_calib_complete goes to 1 on cycle CALIB_CYCLES and stays there until rst.
  - Before calibration completes, app_rdy and app_wdf_rdy are 0.
- Word index: app_addr[ADDR_BITS+2:3]. Higher bits alias (wrap modulo depth). app_addr[2:0] must be 0.
- Write command queue (WCQ): 4 entries, holds word index.
- Write data FIFO (WDF): 4 entries, holds data + mask.
- app_wdf_rdy = calib & WDF not full. Data may precede its command by up to 4 beats, or follow it.
- app_rdy = calib & WCQ not full & !(WCQ non-empty), registered. Reads and further writes are therefore held off until every accepted write command has been paired with its data. This guarantees read-after-write ordering.
  - app_rdy must not depend combinationally on app_cmd or app_en.
- Commit:
  - When WCQ and WDF are both non-empty, pop both in the same cycle.
  - Write RAM with 32 byte enables = ~mask.
  - At most one commit per cycle.
  - A commit and a pop of a newly written entry in the same cycle are legal.
- Read:
  - On an accepted read, the RAM word is fetched and carried through a READ_LATENCY-stage valid/data shift pipeline.
  - Exactly READ_LATENCY cycles later: app_rd_data_valid = app_rd_data_end = 1 for one cycle.
  - Returns are in order. Back-to-back reads give back-to-back returns. There is no backpressure.
- Other app_cmd values are accepted (one cycle of app_rdy consumed), cause no memory access, and set protocol_err.
- protocol_err is also set by:
  - app_wdf_wren & !app_wdf_end;
  - an accepted command with app_addr[2:0] != 0 (the command still executes using the truncated index);
  - app_wdf_wren while app_wdf_rdy = 0 (the beat is dropped).
- protocol_err clears only on rst.
- rst mid-operation: in-flight reads are discarded and produce no valid. Uncommitted writes are discarded.

Optional Feature:
- Macro: MIG_RESP_STALL_EN.
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11), seeded with STALL_SEED at rst, advances every cycle.
  - Bit 0 = 1 forces app_rdy to 0 that cycle.
  - Bit 1 = 1 forces app_wdf_rdy to 0 that cycle.
  - This applies in addition to the normal conditions.
- Undefined: no LFSR logic; ready signals follow the normal rules only.

Test Plan:
- Calibration: release rst at cycle 0 -> init_calib_complete = 0 through cycle 63, = 1 from cycle 64; app_rdy stays 0 before then.
- Basic write then read:
  - Stimulus: write addr 0x000_0040, data 256'h0123...CDEF, mask 0; then read the same address.
  - Required: app_rd_data_valid exactly 8 cycles after read acceptance, data equal, app_rd_data_end = 1.
- Masked write:
  - Stimulus: write all-ones to addr 0x80; then write zeros with mask 32'hFFFF_FFFE; then read.
  - Required: byte 0 = 0x00, bytes 1..31 = 0xFF.
- Data before command:
  - Stimulus: push 4 WDF beats with no command.
  - Required: app_wdf_rdy drops to 0 after the 4th beat. Then issue 4 write commands; reads to those addresses return the matching data in order.
- Aliasing and errors:
  - Stimulus: write to addr (1<<13)|0x8, then read addr 0x8 with ADDR_BITS = 10.
  - Required: the same data is returned. A read with app_addr[2:0] = 3'b100 sets protocol_err = 1.
- Reset mid-read:
  - Stimulus: issue 4 back-to-back reads, then assert rst 3 cycles later.
  - Required: no app_rd_data_valid pulses are ever seen. After re-calibration, RAM contents written earlier read back intact.
